// File: rtl/flit_inject_queue_if.sv
// flit_inject_queue_if: local-port injection handshake plus channel flit buses
interface flit_inject_queue_if #(
    parameter int COORD_W = 3,
    parameter int NCH = 4,
    parameter int DEPTH = 4
);
    localparam int FLIT_W = 2*COORD_W+5;
    logic [NCH*FLIT_W-1:0] in_flit;
    logic                  inj_valid;
    logic [2*COORD_W-1:0]  inj_dest;
    logic                  inj_ready;
    logic [NCH*FLIT_W-1:0] out_flit;
    logic                  eject_valid;
    logic [FLIT_W-1:0]     eject_flit;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  starved;
    modport master(output in_flit, inj_valid, inj_dest,
                   input inj_ready, out_flit, eject_valid, eject_flit, fifo_count, starved);
    modport slave(input in_flit, inj_valid, inj_dest,
                  output inj_ready, out_flit, eject_valid, eject_flit, fifo_count, starved);
endinterface

// File: rtl/flit_inject_queue.sv
// flit_inject_queue: queues local flits and injects the head onto the lowest free channel or ejects it
module flit_inject_queue #(
    parameter int COORD_W = 3,
    parameter int NCH = 4,
    parameter int DEPTH = 4,
    parameter int MY_ROW = 4,
    parameter int MY_COL = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic clk,
    input logic rst_n,
    flit_inject_queue_if.slave bus
);
    localparam int FLIT_W = 2*COORD_W+5;
    localparam int AW = $clog2(DEPTH);
    localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
    localparam int SW = $clog2(STARVE_LIMIT+1);
    localparam logic [COORD_W-1:0] ROW_C = COORD_W'(MY_ROW);
    localparam logic [COORD_W-1:0] COL_C = COORD_W'(MY_COL);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
    logic [2*COORD_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [SW-1:0] wait_cnt;
    logic [NCH*FLIT_W-1:0] out_q, out_d;
    logic eject_valid_q;
    logic [FLIT_W-1:0] eject_flit_q, head_flit;
    logic [COORD_W-1:0] h_row, h_col;
    logic [2:0] dir;
    logic [IW-1:0] idx;
    logic free, is_local, ne, push, pop;
    assign {h_row, h_col} = mem[rd_ptr];
    assign dir = h_col > COL_C ? 3'b000 : h_col < COL_C ? 3'b001 :
                 h_row > ROW_C ? 3'b010 : h_row < ROW_C ? 3'b011 : 3'b100;
    assign head_flit = {2'b10, dir, h_row, h_col};
    assign ne = count != '0;
    assign is_local = dir == 3'b100;
    assign bus.inj_ready = count < DEPTH_C;
    assign push = bus.inj_valid && bus.inj_ready;
    assign pop = ne && (is_local || free);
    // Scan downward so the lowest empty channel wins.
    always_comb begin
        free = 1'b0;
        idx = '0;
        for (int k = NCH-1; k >= 0; k--)
            if (!bus.in_flit[k*FLIT_W+FLIT_W-1]) begin
                free = 1'b1;
                idx = IW'(k);
            end
    end
    always_comb begin
        out_d = bus.in_flit;
        if (pop && !is_local) out_d[idx*FLIT_W +: FLIT_W] = head_flit;
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= bus.inj_dest;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_q <= '0;
            eject_valid_q <= 1'b0;
            eject_flit_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            wait_cnt <= '0;
        end else begin
            out_q <= out_d;
            eject_valid_q <= pop && is_local;
            if (pop && is_local) eject_flit_q <= head_flit;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= push && !pop ? count + 1'b1 : pop && !push ? count - 1'b1 : count;
            wait_cnt <= (!ne || pop) ? '0 : wait_cnt == LIMIT_C ? wait_cnt : wait_cnt + 1'b1;
        end
    assign bus.out_flit = out_q;
    assign bus.eject_valid = eject_valid_q;
    assign bus.eject_flit = eject_flit_q;
    assign bus.fifo_count = count;
    assign bus.starved = wait_cnt == LIMIT_C;
endmodule

// File: doc/flit_inject_queue.md
# flit_inject_queue

Local-port injection stage for the bufferless deflection router. It queues flits from the local processing element in a small FIFO. Each cycle it places the head flit on the lowest-index empty output channel, with the routing direction computed against this router's coordinates. Flits addressed to this router are ejected instead of injected. The block sits between the router's input latches and the permutation/arbitration stage and registers all channel outputs.

## Interface

- COORD_W, 3: bits per mesh coordinate (row, col).
- NCH, 4: channel count; index 0=east, 1=west, 2=north, 3=south.
- DEPTH, 4: injection FIFO entries (≥2, power of two).
- MY_ROW, 4: this router's row.
- MY_COL, 4: this router's col.
- STARVE_LIMIT, 8: wait cycles before `starved` asserts (≥1).
- Derived: FLIT_W = 2*COORD_W+5.
  - Flit fields: [FLIT_W-1] valid, [FLIT_W-2] golden, [FLIT_W-3:2*COORD_W] dir, then row, then col (LSBs).

Ports:

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_flit  in  NCH*FLIT_W  channel flits from input latches; channel k at [k*FLIT_W +: FLIT_W].
- inj_valid  in  1  local PE offers a destination.
- inj_dest  in  2*COORD_W  {row,col} of the destination.
- inj_ready  out  1  FIFO accepts; equals (count < DEPTH).
- out_flit  out  NCH*FLIT_W  registered channel flits to the arbiter.
- eject_valid  out  1  registered; a local-destined queued flit left this cycle.
- eject_flit  out  FLIT_W  registered ejected flit.
- fifo_count  out  clog2(DEPTH)+1  current occupancy.
- starved  out  1  registered; head has waited STARVE_LIMIT cycles.

## Operation

- Push: when inj_valid && inj_ready, {row,col} is written at the tail.
- Head flit is formed combinationally from the FIFO head: valid=1, golden=0, dir from the table below.
- dir table:
  - col>MY_COL: 000 (east).
  - col<MY_COL: 001 (west).
  - col==MY_COL and row>MY_ROW: 010 (north).
  - col==MY_COL and row<MY_ROW: 011 (south).
  - equal coordinates: 100 (local).
- Comparisons are unsigned, COORD_W bits.
- Per cycle, with FIFO non-empty:
  - If head dir==100: pop. Next edge: eject_valid=1, eject_flit=head flit. No channel is consumed.
  - Else if any in_flit channel has valid=0: pick the lowest such index k and pop. Next edge: out_flit[k] = head flit.
  - Else: no pop.
- All other channels pass in_flit through unchanged, including golden and dir bits of occupied flits.
- At most one pop per cycle. The head written at edge t is eligible from cycle t+1; there is no bypass.
- Starvation:
  - The wait counter increments each cycle the FIFO is non-empty and no pop occurs, saturating at STARVE_LIMIT.
  - It clears on pop or when the FIFO is empty.
  - starved = (wait == STARVE_LIMIT). It is a status output only and does not change selection.
- Count: push only gives +1; pop only gives −1; push and pop together leave the count unchanged.
- Full FIFO: inj_ready=0 even if a pop occurs that cycle. Empty FIFO: nothing is injected and out_flit = in_flit registered.

## Timing

- Reset (rst_n low, asynchronous): out_flit=0, eject_valid=0, eject_flit=0, FIFO pointers and count=0, wait=0, starved=0. inj_ready=1 combinationally.
- Reset mid-operation discards queued entries and in-flight outputs immediately.
- Latency: in_flit to out_flit is 1 cycle. FIFO push to earliest injection is 2 edges (write at t, out_flit updated at t+1).
- inj_ready, fifo_count and head dir derive from registered state only; there is no combinational path from inj_valid.
- eject_valid is a 1-cycle pulse per ejected flit. Back-to-back ejections are allowed.

## Test plan

- Reset, then all channels empty, push dest {6,2} → 2 edges later out_flit[0] has valid=1, golden=0, dir=001, row=6, col=2; count returns to 0.
- Channels 0,1 valid and 2,3 empty, push dest {4,7} → out_flit[2] has dir=000; channels 0,1 pass through bit-exact.
- Push dest {4,4} → eject_valid pulses once with eject_flit dir=100; out_flit equals in_flit delayed by 1 cycle.
- All channels valid for 12 cycles with 1 entry queued → starved=1 from cycle 8 onward. Free channel 3 → inject on channel 3, starved drops the next cycle.
- Push 5 entries back-to-back with channels full → inj_ready=0 after the 4th push and the 5th is refused. Free one channel with inj_valid held → pop and refused push same cycle, count 4→3, push accepted the next cycle.
- Assert rst_n low mid-stream with count=3 → outputs zero asynchronously, count=0; after release, empty-channel traffic passes with no stale injections.
